// File: rtl/tmds_encoder_if.sv
// Pixel-side signal bundle for one TMDS channel encoder.
// No valid/ready: the encoder accepts one input set and emits one symbol on every clock.
interface tmds_encoder_if;
  logic [7:0] data_in;
  logic [1:0] control_in;
  logic       ve_in;
  logic [9:0] tmds_out;

  modport master (
    output data_in,
    output control_in,
    output ve_in,
    input  tmds_out
  );

  modport slave (
    input  data_in,
    input  control_in,
    input  ve_in,
    output tmds_out
  );
endinterface

// File: rtl/tmds_encoder.sv
// Registered 8b/10b TMDS channel encoder: transition minimization followed by
// DC balancing against a 5-bit running disparity tally.
module tmds_encoder (
  input  logic           clk_in,
  input  logic           rst_in,
  tmds_encoder_if.slave  enc
);

  logic [9:0]        tmds_q, tmds_d;
  logic signed [4:0] tally_q, tally_d;

  logic [3:0]        n1d;
  logic [3:0]        n1;
  logic              use_xnor;
  logic [8:0]        qm;
  logic signed [4:0] n1_w, n0_w, diff;
  logic              tally_pos, tally_neg, balanced;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d = n1d + {3'd0, enc.data_in[i]};
    end
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !enc.data_in[0]);

    qm    = '0;
    qm[0] = enc.data_in[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ enc.data_in[i]) : (qm[i-1] ^ enc.data_in[i]);
    end
    qm[8] = ~use_xnor;

    n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1 = n1 + {3'd0, qm[i]};
    end
    n1_w = $signed({1'b0, n1});
    n0_w = 5'sd8 - n1_w;
    diff = n1_w - n0_w;

    tally_neg = tally_q[4];
    tally_pos = !tally_q[4] && (tally_q != 5'sd0);
    balanced  = (n1 == 4'd4);
  end

  always_comb begin
    tmds_d  = tmds_q;
    tally_d = tally_q;
    if (!enc.ve_in) begin
      // Blanking resets disparity so the next active line starts balanced.
      tally_d = 5'sd0;
      case (enc.control_in)
        2'b00:   tmds_d = 10'b1101010100;
        2'b01:   tmds_d = 10'b0010101011;
        2'b10:   tmds_d = 10'b0101010100;
        default: tmds_d = 10'b1010101011;
      endcase
    end else if ((tally_q == 5'sd0) || balanced) begin
      tmds_d  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      tally_d = qm[8] ? (tally_q + diff) : (tally_q - diff);
    end else if ((tally_pos && (n1_w > n0_w)) || (tally_neg && (n0_w > n1_w))) begin
      tmds_d  = {1'b1, qm[8], ~qm[7:0]};
      tally_d = tally_q + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      tmds_d  = {1'b0, qm[8], qm[7:0]};
      tally_d = tally_q + diff - (qm[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmds_q  <= 10'd0;
      tally_q <= 5'sd0;
    end else begin
      tmds_q  <= tmds_d;
      tally_q <= tally_d;
    end
  end

  assign enc.tmds_out = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder; expected symbols are hand-derived from the
// TMDS algorithm with the running tally tracked in comments.
module tb_tmds_encoder;

  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_fail;

  tmds_encoder_if bus ();

  tmds_encoder dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .enc    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [9:0] exp);
    n_checks++;
    assert (bus.tmds_out === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, bus.tmds_out, exp);
    end
  endtask

  // Apply one input set, clock it in, then compare the registered symbol.
  task automatic step(input logic rst, input logic ve, input logic [1:0] ctrl,
                      input logic [7:0] data, input string tag, input logic [9:0] exp);
    @(negedge clk_in);
    rst_in         = rst;
    bus.ve_in      = ve;
    bus.control_in = ctrl;
    bus.data_in    = data;
    @(posedge clk_in);
    #1;
    check(tag, exp);
  endtask

  task automatic data(input logic [7:0] d, input string tag, input logic [9:0] exp);
    step(1'b0, 1'b1, 2'($urandom_range(0, 3)), d, tag, exp);
  endtask

  task automatic ctrl(input logic [1:0] c, input string tag, input logic [9:0] exp);
    step(1'b0, 1'b0, c, 8'($urandom_range(0, 255)), tag, exp);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_in         = 1'b1;
    bus.ve_in      = 1'b1;
    bus.data_in    = 8'hA5;
    bus.control_in = 2'b00;

    // Reset held with active data present
    step(1'b1, 1'b1, 2'b00, 8'hA5, "rst0", 10'b0000000000);
    step(1'b1, 1'b1, 2'b00, 8'hA5, "rst1", 10'b0000000000);
    step(1'b1, 1'b1, 2'b00, 8'hA5, "rst2", 10'b0000000000);
    step(1'b1, 1'b0, 2'b11, 8'hA5, "rst_pri_ve0", 10'b0000000000);
    data(8'h00, "post_rst_00", 10'b0100000000);               // t=-8

    // Control codes; also proves the tally is cleared by blanking
    ctrl(2'b00, "ctl00", 10'b1101010100);
    ctrl(2'b01, "ctl01", 10'b0010101011);
    ctrl(2'b10, "ctl10", 10'b0101010100);
    ctrl(2'b11, "ctl11", 10'b1010101011);

    // Disparity walk from tally 0
    data(8'h00, "walk0", 10'b0100000000);                     // t=-8
    data(8'h00, "walk1", 10'b1111111111);                     // t=+2
    data(8'h00, "walk2", 10'b0100000000);                     // t=-6

    // Reset mid-stream, then encode against a cleared tally
    step(1'b1, 1'b1, 2'b00, 8'h00, "mid_rst", 10'b0000000000);
    data(8'h00, "after_mid_rst", 10'b0100000000);             // t=-8

    // Blanking clears tally
    ctrl(2'b00, "blank", 10'b1101010100);
    data(8'h00, "after_blank", 10'b0100000000);               // t=-8

    // XNOR path
    ctrl(2'b10, "blank2", 10'b0101010100);
    data(8'hFF, "xnor0", 10'b1000000000);                     // t=-8
    data(8'hFF, "xnor1_caseC", 10'b0011111111);               // t=-2

    // Mixed walk covering every case and both q_m[8] values
    ctrl(2'b01, "blank3", 10'b0010101011);
    data(8'h01, "mix_A_xor", 10'b0111111111);                 // t=8
    data(8'hFF, "mix_B_xnor", 10'b1000000000);                // t=0
    data(8'h01, "mix_A_again", 10'b0111111111);               // t=8
    data(8'h01, "mix_B_pos0", 10'b1100000000);                // t=2
    data(8'h01, "mix_B_pos1", 10'b1100000000);                // t=-4
    data(8'h01, "mix_C_neg", 10'b0111111111);                 // t=4
    data(8'h00, "mix_C_pos", 10'b0100000000);                 // t=-4
    data(8'hFF, "mix_C_xnor", 10'b0011111111);                // t=2
    data(8'h55, "mix_A_bal_xor", 10'b0100110011);             // t=2
    data(8'hAA, "mix_A_bal_xnor", 10'b1000110011);            // t=2
    data(8'h00, "mix_C_pos2", 10'b0100000000);                // t=-6
    data(8'hFF, "mix_C_to_zero", 10'b0011111111);             // t=0
    data(8'h00, "mix_A_zero", 10'b0100000000);                // t=-8

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Registered 8b/10b TMDS channel encoder for the HDMI/DVI output path. Each cycle it takes an 8-bit pixel component and its 2-bit control symbol. It forms the 9-bit transition-minimized word internally, then applies DC balancing against a running disparity tally. The block emits one 10-bit symbol per pixel clock to the serializer, and one instance is used per colour channel.

## Interface
- No parameters.
- clk_in  input  1  pixel clock; all state updates on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- data_in  input  8  pixel component, sampled when ve_in=1.
- control_in  input  2  control symbol {C1,C0}, sampled when ve_in=0.
- ve_in  input  1  video-active enable: 1 selects data encoding, 0 selects control encoding.
- tmds_out  output  10  registered TMDS symbol, bit 0 transmitted first.

## Operation
- **Transition minimization (combinational).**
  - n1d = number of ones in data_in.
  - If n1d>4, or n1d==4 with data_in[0]==0, use the XNOR chain:
    - q_m[0]=data_in[0]
    - q_m[i]=~(q_m[i-1]^data_in[i]) for i=1..7
    - q_m[8]=0
  - Otherwise use the XOR chain: same recurrence without inversion, and q_m[8]=1.
- **Counts.** N1 = ones in q_m[7:0], N0 = 8−N1. Both are widened to the tally width before subtraction.
- **Tally.** `tally` is a 5-bit two's-complement register, internal only. Under legal operation it stays within [−10,+10], so no saturation logic is needed.
- **Data encoding (ve_in=1), evaluated on the current tally.** Exactly one of three cases applies, checked in this order:
  - **Case A: tally==0 or N1==N0.**
    - tmds_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - If q_m[8]==1: tally += N1−N0; otherwise tally += N0−N1.
  - **Case B: (tally>0 and N1>N0) or (tally<0 and N0>N1).**
    - tmds_out = {1, q_m[8], ~q_m[7:0]}
    - tally += 2·q_m[8] + N0 − N1.
  - **Case C: otherwise.**
    - tmds_out = {0, q_m[8], q_m[7:0]}
    - tally += N1 − N0 − 2·(~q_m[8]).
- **Control encoding (ve_in=0).** The tally is cleared to 0 and tmds_out is set by control_in:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- **Reset.** rst_in has priority over ve_in. It sets tmds_out=0 and tally=0.

## Timing
- **Latency.** One cycle: inputs present before edge k appear on tmds_out after edge k. There is no handshake; a symbol is accepted and emitted every cycle.
- **Tally updates.** The tally and tmds_out update on the same edge. The case decision for edge k uses the tally value from before edge k.
- **Reset values.** tmds_out=10'b0000000000 and tally=0 on the first edge with rst_in=1. They hold while rst_in stays high.
- **Reset mid-stream.** The encoded symbol is discarded, and the next symbol after release is encoded with tally=0.
- **ve_in transitions.**
  - 1→0: the control symbol appears on the next edge and the tally is zeroed on that same edge.
  - 0→1: the first data symbol is encoded against tally=0.
- **Inputs ignored by mode.** data_in is ignored while ve_in=0, and control_in is ignored while ve_in=1.

## Test plan
- **Reset.** Hold rst_in=1 with ve_in=1 and data_in=8'hA5 for 3 cycles → tmds_out=10'b0000000000 every cycle. After release, first data_in=8'h00 → 10'b0100000000.
- **Control codes.** ve_in=0, cycle control_in through 00, 01, 10, 11 → tmds_out is 1101010100, 0010101011, 0101010100, 1010101011, each one cycle later.
- **Disparity walk.** From tally=0, feed data_in=8'h00 three times → tmds_out is 0100000000, 1111111111, 0100000000, with tally −8, +2, −6.
- **XNOR path.** From tally=0, data_in=8'hFF → tmds_out=1000000000 and tally=−8. A following 8'hFF → Case B with N1>N0 false and tally<0: tally<0 and N0>N1 is false, so Case C → 0011111111 and tally=−8+8−2=−2.
- **Reset mid-stream.** After the disparity walk leaves tally=−6, assert rst_in for 1 cycle, then feed 8'h00 → tmds_out=0100000000 (tally was cleared).
- **Blanking clears tally.** After tally=−8, one cycle of ve_in=0 with control_in=00, then 8'h00 → tmds_out is 1101010100 then 0100000000.
